// File: rtl/demux32_stream.sv
// One-to-two stream demultiplexer with a one-word holding register per output port.
// Each port also has a 16-bit counter of the words accepted for it.
module demux32_stream #(
    parameter int W = 31
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W:0]   in_data,
    input  logic         in_sel,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W:0]   a_data,
    output logic         a_valid,
    input  logic         a_ready,
    output logic [W:0]   b_data,
    output logic         b_valid,
    input  logic         b_ready,
    input  logic         clr_cnt,
    output logic [15:0]  cnt_a,
    output logic [15:0]  cnt_b
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t a_state, a_next;
    state_t b_state, b_next;

    logic in_fire;
    logic a_load, b_load;
    logic a_take, b_take;

    assign a_valid = (a_state == FULL);
    assign b_valid = (b_state == FULL);

    // Readiness looks only at the selected port, so a stalled port never blocks the other.
    assign in_ready = rst_n && (in_sel ? (!a_valid || a_ready) : (!b_valid || b_ready));

    assign in_fire = in_valid && in_ready;
    assign a_load  = in_fire && in_sel;
    assign b_load  = in_fire && !in_sel;
    assign a_take  = a_valid && a_ready;
    assign b_take  = b_valid && b_ready;

    // NOTE: next state is defaulted to the current state first so no path leaves it unassigned (no latch).
    always_comb begin
        a_next = a_state;
        b_next = b_state;
        case (a_state)
            EMPTY:   if (a_load)           a_next = FULL;
            FULL:    if (a_take && !a_load) a_next = EMPTY;
            default: a_next = EMPTY;
        endcase
        case (b_state)
            EMPTY:   if (b_load)           b_next = FULL;
            FULL:    if (b_take && !b_load) b_next = EMPTY;
            default: b_next = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_state <= EMPTY;
            b_state <= EMPTY;
        end else begin
            a_state <= a_next;
            b_state <= b_next;
        end
    end

    // NOTE: the holding registers are reset to zero because their post-reset value is observable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_data <= '0;
            b_data <= '0;
        end else begin
            if (a_load) a_data <= in_data;
            if (b_load) b_data <= in_data;
        end
    end

    // A clear coinciding with a transfer leaves the targeted counter at one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_a <= 16'd0;
            cnt_b <= 16'd0;
        end else if (clr_cnt) begin
            cnt_a <= {15'd0, a_load};
            cnt_b <= {15'd0, b_load};
        end else begin
            if (a_load) cnt_a <= cnt_a + 16'd1;
            if (b_load) cnt_b <= cnt_b + 16'd1;
        end
    end

endmodule

// File: tb/tb_demux32_stream.sv
// Directed and randomised self-checking bench for demux32_stream.
// A one-word-per-port reference model predicts readiness, data and counters.
module tb_demux32_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_data;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] b_data;
    logic        b_valid;
    logic        b_ready;
    logic        clr_cnt;
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;

    int checks = 0;
    int errors = 0;

    demux32_stream #(.W(31)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .clr_cnt  (clr_cnt),
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [31:0] d,
                         input logic ar, input logic br);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
    endtask

    // Reference model state for the random phase
    logic        m_full_a, m_full_b;
    logic [31:0] m_data_a, m_data_b;
    logic [15:0] m_cnt_a, m_cnt_b;

    initial begin
        rst_n   = 1'b0;
        clr_cnt = 1'b0;
        drive(1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b1);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("rst_a_valid", {31'd0, a_valid}, 32'd0);
        check("rst_b_valid", {31'd0, b_valid}, 32'd0);
        check("rst_a_data", a_data, 32'd0);
        check("rst_b_data", b_data, 32'd0);
        check("rst_cnt_a", {16'd0, cnt_a}, 32'd0);
        check("rst_cnt_b", {16'd0, cnt_b}, 32'd0);

        // First word after release goes to A with one cycle of latency
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
        #1;
        check("first_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("first_a_valid", {31'd0, a_valid}, 32'd1);
        check("first_a_data", a_data, 32'hDEAD_BEEF);
        check("first_b_valid", {31'd0, b_valid}, 32'd0);
        check("first_cnt_a", {16'd0, cnt_a}, 32'd1);
        check("first_cnt_b", {16'd0, cnt_b}, 32'd0);

        // A stalled: A-bound word refused, B-bound word still accepted
        drive(1'b1, 1'b1, 32'h1111_1111, 1'b0, 1'b0);
        #1;
        check("stall_a_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("stall_a_valid", {31'd0, a_valid}, 32'd1);
        check("stall_a_data", a_data, 32'hDEAD_BEEF);
        check("stall_cnt_a", {16'd0, cnt_a}, 32'd1);
        drive(1'b1, 1'b0, 32'h0000_0005, 1'b0, 1'b0);
        #1;
        check("bypass_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("bypass_b_valid", {31'd0, b_valid}, 32'd1);
        check("bypass_b_data", b_data, 32'h0000_0005);
        check("bypass_cnt_b", {16'd0, cnt_b}, 32'd1);
        check("bypass_a_data", a_data, 32'hDEAD_BEEF);

        // Drain B, then refill with 1 and replace with 2 in the same cycle 1 is taken
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        check("drain_b_valid", {31'd0, b_valid}, 32'd0);
        drive(1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h0000_0002, 1'b0, 1'b1);
        #1;
        check("pass_in_ready", {31'd0, in_ready}, 32'd1);
        check("pass_seen_1", b_data, 32'h0000_0001);
        tick();
        check("pass_b_valid", {31'd0, b_valid}, 32'd1);
        check("pass_seen_2", b_data, 32'h0000_0002);
        check("pass_cnt_b", {16'd0, cnt_b}, 32'd3);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        check("empty_b_valid", {31'd0, b_valid}, 32'd0);
        check("empty_b_retain", b_data, 32'h0000_0002);

        // Both ports full, then a one-cycle reset discards both words
        drive(1'b1, 1'b0, 32'h0000_0077, 1'b0, 1'b0);
        tick();
        check("both_full_a", {31'd0, a_valid}, 32'd1);
        check("both_full_b", {31'd0, b_valid}, 32'd1);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_0099, 1'b0, 1'b0);
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        check("midrst_a_valid", {31'd0, a_valid}, 32'd0);
        check("midrst_b_valid", {31'd0, b_valid}, 32'd0);
        check("midrst_cnt_a", {16'd0, cnt_a}, 32'd0);
        check("midrst_cnt_b", {16'd0, cnt_b}, 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        check("post_rst_a_valid", {31'd0, a_valid}, 32'd0);
        check("post_rst_b_valid", {31'd0, b_valid}, 32'd0);

        // Counter wrap: 65535 A transfers, then one more
        drive(1'b1, 1'b1, 32'hA5A5_0000, 1'b1, 1'b1);
        repeat (65535) @(posedge clk);
        #1;
        check("cnt_a_max", {16'd0, cnt_a}, 32'h0000_FFFF);
        tick();
        check("cnt_a_wrap", {16'd0, cnt_a}, 32'd0);
        drive(1'b1, 1'b0, 32'h0000_0B0B, 1'b1, 1'b1);
        tick();
        tick();
        drive(1'b1, 1'b1, 32'h0000_0A0A, 1'b1, 1'b1);
        tick();
        check("pre_clr_cnt_a", {16'd0, cnt_a}, 32'd1);
        check("pre_clr_cnt_b", {16'd0, cnt_b}, 32'd2);
        clr_cnt = 1'b1;
        drive(1'b1, 1'b0, 32'h0000_0C0C, 1'b1, 1'b1);
        tick();
        check("clr_xfer_cnt_a", {16'd0, cnt_a}, 32'd0);
        check("clr_xfer_cnt_b", {16'd0, cnt_b}, 32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        check("clr_idle_cnt_b", {16'd0, cnt_b}, 32'd0);
        clr_cnt = 1'b0;

        // Random traffic against the reference model, starting from a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        m_full_a = 1'b0;
        m_full_b = 1'b0;
        m_data_a = '0;
        m_data_b = '0;
        m_cnt_a  = '0;
        m_cnt_b  = '0;
        for (int i = 0; i < 10000; i++) begin
            logic exp_ready, push_a, push_b, pop_a, pop_b;
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
            #1;
            check("rnd_a_valid", {31'd0, a_valid}, {31'd0, m_full_a});
            check("rnd_b_valid", {31'd0, b_valid}, {31'd0, m_full_b});
            if (m_full_a) check("rnd_a_data", a_data, m_data_a);
            if (m_full_b) check("rnd_b_data", b_data, m_data_b);
            exp_ready = in_sel ? (!m_full_a || a_ready) : (!m_full_b || b_ready);
            check("rnd_in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
            push_a = in_valid && exp_ready && in_sel;
            push_b = in_valid && exp_ready && !in_sel;
            pop_a  = m_full_a && a_ready;
            pop_b  = m_full_b && b_ready;
            if (push_a) begin m_data_a = in_data; m_cnt_a = m_cnt_a + 16'd1; end
            if (push_b) begin m_data_b = in_data; m_cnt_b = m_cnt_b + 16'd1; end
            m_full_a = push_a || (m_full_a && !pop_a);
            m_full_b = push_b || (m_full_b && !pop_b);
            tick();
        end
        check("rnd_cnt_a", {16'd0, cnt_a}, {16'd0, m_cnt_a});
        check("rnd_cnt_b", {16'd0, cnt_b}, {16'd0, m_cnt_b});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux32_stream.md
DEMUX32_STREAM -- requirements
Module: demux32_stream

Interface
REQ-001 Parameter W, default 31, MSB index of the data path; data width is W+1 bits.
REQ-002 clk  input  1  the only clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 in_data  input  W+1  word offered by the upstream producer.
REQ-005 in_sel  input  1  destination select: 1 routes to port A, 0 routes to port B.
REQ-006 in_valid  input  1  upstream has a word on in_data/in_sel.
REQ-007 in_ready  output  1  block accepts the word this cycle.
REQ-008 a_data  output  W+1  port A held word.
REQ-009 a_valid  output  1  port A holds a word.
REQ-010 a_ready  input  1  port A consumer accepts this cycle.
REQ-011 b_data, b_valid, b_ready: as REQ-008..010, for port B.
REQ-012 clr_cnt  input  1  synchronous clear of both transfer counters.
REQ-013 cnt_a  output  16  count of words accepted for port A.
REQ-014 cnt_b  output  16  count of words accepted for port B.

Function
REQ-015 Input transfer occurs when in_valid && in_ready on a rising edge; output transfer on port X when x_valid && x_ready.
REQ-016 Each port has a one-word holding register with a two-state FSM: EMPTY (x_valid=0) and FULL (x_valid=1).
REQ-017 EMPTY -> FULL on an input transfer targeting that port; FULL -> EMPTY on an output transfer with no input transfer to that port; FULL -> FULL on simultaneous output and input transfers, register loads the new word.
REQ-018 in_ready is combinational: 1 when the port selected by in_sel is EMPTY, or FULL with its x_ready=1; otherwise 0.
REQ-019 in_ready does not depend on the state of the non-selected port; a stalled port never blocks traffic to the other port.
REQ-020 Latency: a word accepted at edge N appears on x_data with x_valid=1 after edge N, i.e. one cycle.
REQ-021 x_data is stable and x_valid stays 1 while FULL and x_ready=0.
REQ-022 x_data of an EMPTY port retains its last value; a consumer ignores it.
REQ-023 Words to the same port are delivered in acceptance order; no word is dropped or duplicated.
REQ-024 cnt_a increments by 1 on each input transfer with in_sel=1; cnt_b on each with in_sel=0; both wrap from 16'hFFFF to 0.
REQ-025 clr_cnt=1 sets both counters to 0; if an input transfer occurs in the same cycle, the targeted counter becomes 1.
REQ-026 in_sel and in_data are ignored when in_valid=0.

Reset
REQ-027 While rst_n=0 at a rising edge: a_valid=0, b_valid=0, a_data=0, b_data=0, cnt_a=0, cnt_b=0, both FSMs EMPTY.
REQ-028 in_ready is 0 during any cycle with rst_n=0; no transfer is accepted.
REQ-029 Reset mid-operation discards held words without delivering them; the first cycle after release behaves as a fresh start.

Verification
REQ-030 Reset release, in_valid=1, in_sel=1, in_data=32'hDEADBEEF, a_ready=1 -> next cycle a_valid=1, a_data=DEADBEEF, b_valid=0, cnt_a=1, cnt_b=0.
REQ-031 Port A FULL, a_ready=0; offer in_sel=1 -> in_ready=0, a_data unchanged; offer in_sel=0, 32'h00000005 -> in_ready=1, b_valid=1, b_data=5 next cycle.
REQ-032 Port B FULL with 32'h1, b_ready=1, offer in_sel=0 with 32'h2 -> in_ready=1, next cycle b_valid=1, b_data=2, consumer saw 1 then 2.
REQ-033 Preload cnt_a to 16'hFFFF via 65535 transfers, one more A transfer -> cnt_a=0; clr_cnt=1 with a B transfer -> cnt_a=0, cnt_b=1.
REQ-034 Both ports FULL, assert rst_n=0 for one cycle -> a_valid=b_valid=0, counters 0, in_ready=0 during reset, held words never delivered.
REQ-035 Random traffic, random a_ready/b_ready, 10000 cycles -> scoreboard per port shows in-order, loss-free delivery and counters equal to accepted words mod 65536.
